// File: rtl/rr_lock_arbiter.sv
// rr_lock_arbiter: N-input valid/ready arbiter with address payload, round-robin or fixed-priority grant.
// Latency: zero cycles; out_valid/address/chosen/in_ready are combinational from state and inputs.
// Backpressure: a stalled grant is locked until it fires, so the payload stays stable and later arrivals wait.
// Ports:
//   clock, reset                      single clock, synchronous active-high reset
//   io_in_valid / io_in_ready         per-requester handshake, bit i = requester i
//   io_in_bits_address                packed payloads, requester i at [i*ADDR_W +: ADDR_W]
//   io_out_valid / io_out_ready       arbitrated handshake toward the shared channel
//   io_out_bits_address / _chosen     payload and index of the granted requester
module rr_lock_arbiter #(
  parameter int N_IN    = 4,
  parameter int ADDR_W  = 32,
  parameter int RR_MODE = 1,
  localparam int CHOSEN_W = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_IN-1:0]          io_in_valid,
  input  logic [N_IN*ADDR_W-1:0]   io_in_bits_address,
  output logic [N_IN-1:0]          io_in_ready,
  output logic                     io_out_valid,
  output logic [ADDR_W-1:0]        io_out_bits_address,
  output logic [CHOSEN_W-1:0]      io_out_bits_chosen,
  input  logic                     io_out_ready
);

  logic [CHOSEN_W-1:0] last_grant;
  logic                locked;
  logic [CHOSEN_W-1:0] lock_idx;

  logic [CHOSEN_W-1:0] search_start;
  logic [CHOSEN_W-1:0] free_grant;
  logic                free_found;
  logic [CHOSEN_W-1:0] grant;
  logic                sel_valid;
  logic                fire;
  int                  cand;

  // Unlocked choice: scan N_IN candidates starting after the last winner
  // (or at 0 in fixed-priority mode). The wrap is an explicit compare so
  // non-power-of-2 N_IN never produces an index >= N_IN.
  always_comb begin
    search_start = '0;
    if (RR_MODE != 0) begin
      search_start = (last_grant == CHOSEN_W'(N_IN - 1)) ? '0
                                                          : last_grant + CHOSEN_W'(1);
    end
    free_grant = '0;
    free_found = 1'b0;
    cand       = 0;
    for (int k = 0; k < N_IN; k++) begin
      cand = int'(search_start) + k;
      if (cand >= N_IN) cand = cand - N_IN;
      if (!free_found && io_in_valid[cand]) begin
        free_found = 1'b1;
        free_grant = CHOSEN_W'(cand);
      end
    end
  end

  // A held grant ignores every other requester until it fires or withdraws.
  assign grant = locked ? lock_idx : free_grant;

  always_comb begin
    sel_valid           = 1'b0;
    io_out_bits_address = io_in_bits_address[ADDR_W-1:0];
    for (int i = 0; i < N_IN; i++) begin
      if (grant == CHOSEN_W'(i)) begin
        sel_valid           = io_in_valid[i];
        io_out_bits_address = io_in_bits_address[i*ADDR_W +: ADDR_W];
      end
    end
  end

  assign io_out_valid       = sel_valid & ~reset;
  assign io_out_bits_chosen = grant;
  assign fire               = io_out_valid & io_out_ready;

  always_comb begin
    for (int i = 0; i < N_IN; i++) begin
      io_in_ready[i] = fire & (grant == CHOSEN_W'(i));
    end
  end

  // Reset value N_IN-1 makes the first round-robin search begin at index 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant <= CHOSEN_W'(N_IN - 1);
      locked     <= 1'b0;
      lock_idx   <= '0;
    end else if (fire) begin
      locked <= 1'b0;
      if (RR_MODE != 0) last_grant <= grant;
    end else if (io_out_valid) begin
      // Stalled: hold this grant so the payload cannot change under the consumer.
      locked   <= 1'b1;
      lock_idx <= grant;
    end else if (locked) begin
      // Held requester dropped valid; release and re-arbitrate next cycle.
      locked <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && io_out_valid) begin
      assert (int'(io_out_bits_chosen) < N_IN);
    end
  end

endmodule

// File: tb/tb_rr_lock_arbiter.sv
module tb_rr_lock_arbiter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic         reset = 1'b1;
  logic [3:0]   valid4 = '0;
  logic [127:0] addr4 = '0;
  logic         rdy4 = 1'b0;
  logic [3:0]   rr_ready, fp_ready;
  logic         rr_ov, fp_ov;
  logic [31:0]  rr_oa, fp_oa;
  logic [1:0]   rr_oc, fp_oc;

  logic [2:0]   valid3 = '0;
  logic [95:0]  addr3 = '0;
  logic         rdy3 = 1'b0;
  logic [2:0]   t_ready;
  logic         t_ov;
  logic [31:0]  t_oa;
  logic [1:0]   t_oc;

  int checks = 0;
  int errors = 0;

  rr_lock_arbiter #(.N_IN(4), .ADDR_W(32), .RR_MODE(1)) u_rr4 (
    .clock(clock), .reset(reset), .io_in_valid(valid4), .io_in_bits_address(addr4),
    .io_in_ready(rr_ready), .io_out_valid(rr_ov), .io_out_bits_address(rr_oa),
    .io_out_bits_chosen(rr_oc), .io_out_ready(rdy4));

  rr_lock_arbiter #(.N_IN(4), .ADDR_W(32), .RR_MODE(0)) u_fp4 (
    .clock(clock), .reset(reset), .io_in_valid(valid4), .io_in_bits_address(addr4),
    .io_in_ready(fp_ready), .io_out_valid(fp_ov), .io_out_bits_address(fp_oa),
    .io_out_bits_chosen(fp_oc), .io_out_ready(rdy4));

  rr_lock_arbiter #(.N_IN(3), .ADDR_W(32), .RR_MODE(1)) u_rr3 (
    .clock(clock), .reset(reset), .io_in_valid(valid3), .io_in_bits_address(addr3),
    .io_in_ready(t_ready), .io_out_valid(t_ov), .io_out_bits_address(t_oa),
    .io_out_bits_chosen(t_oc), .io_out_ready(rdy3));

  // Reference: held index wins; otherwise first valid scanning from the
  // position after the previous winner (or from 0 for fixed priority).
  function automatic int ref_grant(input int n, input bit rr, input int last,
                                   input int held, input logic [3:0] v);
    int start;
    if (held >= 0) return held;
    start = rr ? (last + 1) % n : 0;
    for (int k = 0; k < n; k++) begin
      if (v[(start + k) % n]) return (start + k) % n;
    end
    return 0;
  endfunction

  task automatic ref_update(input bit rr, input logic [3:0] v, input logic rdy,
                            input int g, inout int last, inout int held);
    if (v[g] && rdy) begin
      held = -1;
      if (rr) last = g;
    end else if (v[g]) begin
      held = g;
    end else begin
      held = -1;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic rand_addr();
    for (int i = 0; i < 4; i++) addr4[i*32 +: 32] = $urandom;
    for (int i = 0; i < 3; i++) addr3[i*32 +: 32] = $urandom;
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    reset = 1'b1; valid4 = 4'b1111; rdy4 = 1'b1; valid3 = 3'b111; rdy3 = 1'b1;
    rand_addr();
    tick();
    @(negedge clock);
    checks++; if (rr_ov !== 1'b0) begin errors++; $display("FAIL reset_rr_valid got %b exp 0", rr_ov); end
    checks++; if (rr_ready !== 4'b0) begin errors++; $display("FAIL reset_rr_ready got %b exp 0000", rr_ready); end
    checks++; if (fp_ov !== 1'b0 || fp_ready !== 4'b0) begin errors++; $display("FAIL reset_fp valid %b ready %b exp 0/0000", fp_ov, fp_ready); end
    checks++; if (t_ov !== 1'b0 || t_ready !== 3'b0) begin errors++; $display("FAIL reset_n3 valid %b ready %b exp 0/000", t_ov, t_ready); end
    tick();
    reset = 1'b0;
    @(negedge clock);
    checks++; if (rr_ov !== 1'b1 || rr_oc !== 2'd0) begin errors++; $display("FAIL reset_first_grant valid %b chosen %0d exp 1/0", rr_ov, rr_oc); end
    checks++; if (t_oc !== 2'd0) begin errors++; $display("FAIL reset_first_grant_n3 chosen %0d exp 0", t_oc); end
    tick();
  endtask

  task automatic test_rr_sequence();
    logic [3:0] exp_r;
    do_reset();
    valid4 = 4'b1111; rdy4 = 1'b1;
    for (int c = 0; c < 8; c++) begin
      rand_addr();
      exp_r = 4'(1 << (c % 4));
      @(negedge clock);
      checks++; if (rr_oc !== 2'(c % 4)) begin errors++; $display("FAIL rr_seq cyc %0d chosen %0d exp %0d", c, rr_oc, c % 4); end
      checks++; if (rr_ready !== exp_r) begin errors++; $display("FAIL rr_seq_ready cyc %0d got %b exp %b", c, rr_ready, exp_r); end
      checks++; if (rr_oa !== addr4[(c % 4)*32 +: 32]) begin errors++; $display("FAIL rr_seq_addr cyc %0d got %h exp %h", c, rr_oa, addr4[(c % 4)*32 +: 32]); end
      checks++; if (fp_oc !== 2'd0) begin errors++; $display("FAIL fp_all_valid cyc %0d chosen %0d exp 0", c, fp_oc); end
      tick();
    end
  endtask

  task automatic test_fixed_priority();
    do_reset();
    valid4 = 4'b1010; rdy4 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      rand_addr();
      @(negedge clock);
      checks++; if (fp_ov !== 1'b1 || fp_oc !== 2'd1) begin errors++; $display("FAIL fp_prio cyc %0d valid %b chosen %0d exp 1/1", c, fp_ov, fp_oc); end
      checks++; if (fp_ready !== 4'b0010) begin errors++; $display("FAIL fp_prio_ready cyc %0d got %b exp 0010", c, fp_ready); end
      tick();
    end
  endtask

  task automatic test_lock_stall();
    logic [31:0] p2;
    do_reset();
    valid4 = 4'b0100; rdy4 = 1'b0;
    rand_addr();
    p2 = addr4[64 +: 32];
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      checks++; if (rr_ov !== 1'b1 || rr_oc !== 2'd2) begin errors++; $display("FAIL stall_hold cyc %0d valid %b chosen %0d exp 1/2", c, rr_ov, rr_oc); end
      checks++; if (rr_oa !== p2 || rr_ready !== 4'b0) begin errors++; $display("FAIL stall_addr cyc %0d addr %h ready %b exp %h/0000", c, rr_oa, rr_ready, p2); end
      tick();
    end
    valid4 = 4'b0101; rdy4 = 1'b1;
    @(negedge clock);
    checks++; if (rr_oc !== 2'd2 || rr_ready !== 4'b0100) begin errors++; $display("FAIL stall_fire chosen %0d ready %b exp 2/0100", rr_oc, rr_ready); end
    checks++; if (fp_oc !== 2'd2 || fp_ready !== 4'b0100) begin errors++; $display("FAIL fp_lock_ignores_0 chosen %0d ready %b exp 2/0100", fp_oc, fp_ready); end
    tick();
    @(negedge clock);
    checks++; if (rr_oc !== 2'd0 || rr_ready !== 4'b0001) begin errors++; $display("FAIL after_fire chosen %0d ready %b exp 0/0001", rr_oc, rr_ready); end
    tick();
  endtask

  task automatic test_withdraw();
    do_reset();
    valid4 = 4'b0010; rdy4 = 1'b0;
    rand_addr();
    tick();
    @(negedge clock);
    checks++; if (rr_oc !== 2'd1 || rr_ov !== 1'b1) begin errors++; $display("FAIL withdraw_hold chosen %0d valid %b exp 1/1", rr_oc, rr_ov); end
    tick();
    valid4 = 4'b1000;
    @(negedge clock);
    checks++; if (rr_ov !== 1'b0 || rr_ready !== 4'b0) begin errors++; $display("FAIL withdraw_cycle valid %b ready %b exp 0/0000", rr_ov, rr_ready); end
    tick();
    @(negedge clock);
    checks++; if (rr_ov !== 1'b1 || rr_oc !== 2'd3) begin errors++; $display("FAIL withdraw_next valid %b chosen %0d exp 1/3", rr_ov, rr_oc); end
    tick();
  endtask

  task automatic test_wrap3();
    do_reset();
    valid3 = 3'b100; rdy3 = 1'b1;
    rand_addr();
    @(negedge clock);
    checks++; if (t_oc !== 2'd2 || t_ready !== 3'b100) begin errors++; $display("FAIL n3_last chosen %0d ready %b exp 2/100", t_oc, t_ready); end
    tick();
    valid3 = 3'b111;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      checks++; if (t_oc !== 2'(c % 3)) begin errors++; $display("FAIL n3_wrap cyc %0d chosen %0d exp %0d", c, t_oc, c % 3); end
      tick();
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    valid4 = 4'b0100; rdy4 = 1'b0;
    rand_addr();
    tick();
    tick();
    @(negedge clock);
    checks++; if (rr_oc !== 2'd2) begin errors++; $display("FAIL midreset_lock chosen %0d exp 2", rr_oc); end
    tick();
    reset = 1'b1; valid4 = 4'b1111;
    @(negedge clock);
    checks++; if (rr_ov !== 1'b0 || rr_ready !== 4'b0) begin errors++; $display("FAIL midreset_out valid %b ready %b exp 0/0000", rr_ov, rr_ready); end
    tick();
    reset = 1'b0; rdy4 = 1'b1;
    @(negedge clock);
    checks++; if (rr_oc !== 2'd0 || rr_ready !== 4'b0001) begin errors++; $display("FAIL midreset_restart chosen %0d ready %b exp 0/0001", rr_oc, rr_ready); end
    tick();
  endtask

  task automatic test_random();
    int rl, rh, fl, fh, tl, th;
    int rg, fg, tg;
    logic [3:0] v3;
    logic [3:0] er, ef;
    logic [2:0] et;
    do_reset();
    rl = 3; rh = -1; fl = 3; fh = -1; tl = 2; th = -1;
    for (int c = 0; c < 400; c++) begin
      valid4 = 4'($urandom);
      rdy4   = ($urandom_range(0, 2) != 0);
      valid3 = 3'($urandom);
      rdy3   = ($urandom_range(0, 2) != 0);
      rand_addr();
      v3 = {1'b0, valid3};
      rg = ref_grant(4, 1'b1, rl, rh, valid4);
      fg = ref_grant(4, 1'b0, fl, fh, valid4);
      tg = ref_grant(3, 1'b1, tl, th, v3);
      er = (valid4[rg] && rdy4) ? 4'(1 << rg) : 4'b0;
      ef = (valid4[fg] && rdy4) ? 4'(1 << fg) : 4'b0;
      et = (v3[tg] && rdy3) ? 3'(1 << tg) : 3'b0;
      @(negedge clock);
      checks++; if (rr_oc !== 2'(rg) || rr_ov !== valid4[rg]) begin errors++; $display("FAIL rand_rr cyc %0d chosen %0d valid %b exp %0d/%b", c, rr_oc, rr_ov, rg, valid4[rg]); end
      checks++; if (rr_oa !== addr4[rg*32 +: 32] || rr_ready !== er) begin errors++; $display("FAIL rand_rr_data cyc %0d addr %h ready %b exp %h/%b", c, rr_oa, rr_ready, addr4[rg*32 +: 32], er); end
      checks++; if (fp_oc !== 2'(fg) || fp_ov !== valid4[fg]) begin errors++; $display("FAIL rand_fp cyc %0d chosen %0d valid %b exp %0d/%b", c, fp_oc, fp_ov, fg, valid4[fg]); end
      checks++; if (fp_oa !== addr4[fg*32 +: 32] || fp_ready !== ef) begin errors++; $display("FAIL rand_fp_data cyc %0d addr %h ready %b exp %h/%b", c, fp_oa, fp_ready, addr4[fg*32 +: 32], ef); end
      checks++; if (t_oc !== 2'(tg) || t_ov !== v3[tg]) begin errors++; $display("FAIL rand_n3 cyc %0d chosen %0d valid %b exp %0d/%b", c, t_oc, t_ov, tg, v3[tg]); end
      checks++; if (t_oa !== addr3[tg*32 +: 32] || t_ready !== et) begin errors++; $display("FAIL rand_n3_data cyc %0d addr %h ready %b exp %h/%b", c, t_oa, t_ready, addr3[tg*32 +: 32], et); end
      ref_update(1'b1, valid4, rdy4, rg, rl, rh);
      ref_update(1'b0, valid4, rdy4, fg, fl, fh);
      ref_update(1'b1, v3, rdy3, tg, tl, th);
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_rr_sequence();
    test_fixed_priority();
    test_lock_stall();
    test_withdraw();
    test_wrap3();
    test_reset_mid_stall();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
